// File: rtl/reg_scoreboard_if.sv
// ID/WB handshake bundle between the decode stage and the register scoreboard.
interface reg_scoreboard_if;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [4:0]  id_dest;
    logic        id_gr_we;
    logic        issue;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic        flush;
    logic        stall;
    logic [31:0] busy_vec;
    logic [2:0]  inflight;
    logic        err;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_gr_we,
               issue, wb_we, wb_dest, flush,
        input  stall, busy_vec, inflight, err
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_gr_we,
               issue, wb_we, wb_dest, flush,
        output stall, busy_vec, inflight, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters, issue stall
// generation and a sticky protocol-error flag.
module reg_scoreboard (
    input  logic            clk,
    input  logic            reset,
    reg_scoreboard_if.slave sb
);
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned CW   = 2;
    localparam int unsigned IW   = 3;
    localparam logic [CW-1:0] CNT_MAX      = 2'd3;
    localparam logic [IW-1:0] INFLIGHT_MAX = 3'd4;

    logic [CW-1:0]   cnt   [NREG];
    logic [CW-1:0]   cnt_n [NREG];
    logic [NREG-1:0] busy_n;
    logic [IW-1:0]   inflight_n;

    logic rs_hit, rt_hit, dest_full;
    logic accept, inc, wb_hit, dec, issue_err, wb_err;

    // Hazard check uses registered state only, so a WB this cycle releases next cycle.
    always_comb begin
        rs_hit    = sb.id_rs_used && (sb.id_rs != '0) && sb.busy_vec[sb.id_rs];
        rt_hit    = sb.id_rt_used && (sb.id_rt != '0) && sb.busy_vec[sb.id_rt];
        dest_full = sb.id_gr_we && (sb.id_dest != '0) &&
                    ((cnt[sb.id_dest] == CNT_MAX) || (sb.inflight == INFLIGHT_MAX));
        sb.stall  = sb.id_valid && (rs_hit || rt_hit || dest_full);
    end

    always_comb begin
        accept    = sb.issue && sb.id_valid && !sb.stall;
        inc       = accept && sb.id_gr_we && (sb.id_dest != '0);
        issue_err = sb.issue && !accept;
        wb_hit    = sb.wb_we && (sb.wb_dest != '0);
        dec       = wb_hit && (cnt[sb.wb_dest] != '0);
        wb_err    = wb_hit && (cnt[sb.wb_dest] == '0);
    end

    // Next counter state; flush wins over issue and writeback.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_n[i] = cnt[i];
        end
        inflight_n = sb.inflight;
        busy_n     = '0;
        if (sb.flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_n[i] = '0;
            end
            inflight_n = '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                cnt_n[i] = cnt[i] + CW'(inc && (sb.id_dest == RW'(i)))
                                  - CW'(dec && (sb.wb_dest == RW'(i)));
            end
            inflight_n = sb.inflight + IW'(inc) - IW'(dec);
        end
        cnt_n[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_n[i] = (cnt_n[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            sb.busy_vec <= '0;
            sb.inflight <= '0;
            sb.err      <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= cnt_n[i];
            end
            sb.busy_vec <= busy_n;
            sb.inflight <= inflight_n;
            sb.err      <= sb.err | issue_err | wb_err;
        end
    end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset; no other clock or reset exists.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 id_valid  input  1  ID stage holds a valid instruction.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the ID instruction.
REQ-006 id_rs_used, id_rt_used  input  1 each  the instruction actually reads rs / rt.
REQ-007 id_dest  input  5  destination register of the ID instruction.
REQ-008 id_gr_we  input  1  the ID instruction writes the register file.
REQ-009 issue  input  1  the ID instruction leaves ID this cycle (ds_to_es_valid && es_allowin).
REQ-010 wb_we  input  1  the WB stage writes the register file this cycle.
REQ-011 wb_dest  input  5  register written by WB.
REQ-012 flush  input  1  discard all in-flight writes.
REQ-013 stall  output  1  combinational; the ID instruction must not issue.
REQ-014 busy_vec  output  32  registered; bit i = register i has at least one pending write.
REQ-015 inflight  output  3  registered; total pending writes, range 0..4.
REQ-016 err  output  1  registered sticky protocol-error flag.

Function
REQ-017 Per-register state SHALL be a 2-bit pending counter for registers 1..31; register 0 SHALL never be tracked, and busy_vec[0] SHALL always be 0.
REQ-018 busy_vec[i] SHALL equal (counter[i] != 0).
REQ-019 An issue SHALL be accepted when issue=1, id_valid=1 and stall=0.
REQ-020 An accepted issue with id_gr_we=1 and id_dest!=0 SHALL increment counter[id_dest] and inflight at the next edge.
REQ-021 wb_we=1 with wb_dest!=0 SHALL decrement counter[wb_dest] and inflight at the next edge.
REQ-022 A same-cycle increment and decrement of the same register SHALL leave counter and inflight unchanged.
REQ-023 stall SHALL be 1 iff id_valid=1 and any of the following holds:
 - id_rs_used=1, id_rs!=0 and busy_vec[id_rs]=1;
 - id_rt_used=1, id_rt!=0 and busy_vec[id_rt]=1;
 - id_gr_we=1, id_dest!=0 and counter[id_dest]=3;
 - id_gr_we=1, id_dest!=0 and inflight=4.
REQ-024 A WB write in the current cycle SHALL NOT clear stall in that cycle; release is visible one cycle after the WB edge.
REQ-025 issue=1 while stall=1 or id_valid=0 SHALL be ignored (no state change) and SHALL set err.
REQ-026 wb_we=1 with wb_dest!=0 and counter[wb_dest]=0 SHALL set err and leave counter[wb_dest] and inflight unchanged.
REQ-027 flush=1 SHALL clear all counters and inflight at the next edge, with priority over issue and WB in the same cycle; err is unaffected.
REQ-028 err, once set, SHALL remain 1 until reset.
REQ-029 Counters and inflight SHALL never wrap: they do not exceed 3 and 4 respectively and do not go below 0.

Reset
REQ-030 With reset=1 at a posedge, all counters, busy_vec, inflight and err SHALL be 0 after that edge, and stall SHALL be 0 unless a source check would fire.
REQ-031 reset SHALL take priority over flush, issue and WB, including a reset asserted while writes are in flight.

Verification
REQ-032 Reset, then idle one cycle -> busy_vec=0, inflight=0, err=0, stall=0.
REQ-033 Issue dest=5; next cycle id_rs=5, id_rs_used=1 -> stall=1; wb_we with wb_dest=5 -> stall stays 1 that cycle and is 0 the following cycle, with busy_vec[5]=0.
REQ-034 Issue dest=0 with gr_we=1 -> busy_vec=0 and inflight=0; later id_rs=0 -> stall=0.
REQ-035 With counter[7]=1, issue dest=7 and wb dest=7 in the same cycle -> busy_vec[7]=1, inflight unchanged.
REQ-036 Issue dest=9 three times -> stall=1 for a fourth dest=9; issue four distinct dests -> inflight=4 and stall=1 for a fifth.
REQ-037 wb_we to r3 while idle -> err=1, inflight=0; then flush with two pending writes -> busy_vec=0, inflight=0, err stays 1 until reset.
